sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO with integrated storage, pointer management, occupancy count and status flags. It generalises the team's dual-port FIFO memory into a self-contained buffer: width, depth and almost-full/almost-empty thresholds are configurable, and it adds error pulses for rejected accesses. It sits between same-clock producer/consumer stages as the standard elastic buffer.

---
 rtl/sync_fifo_param.sv | 115 +++++++++++
 tb/tb_sync_fifo_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags
// and one-cycle overflow/underflow pulses for rejected accesses.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        rd_en_i,
  output logic [DATA_W-1:0]           data_o,
  output logic                        valid_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
  localparam logic [ADDR_W:0]   CNT_DEPTH = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_AF    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_AE    = AE_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_count_nxt;

  // Handshake: a request is accepted at an edge when its enable is high and the
  // registered full/empty flag (pre-edge) permits it; there is no backpressure
  // beyond those flags, and valid_o marks one registered read result per accept.
  assign w_wr_acc = wr_en_i & ~r_full;
  assign w_rd_acc = rd_en_i & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is intentionally not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_valid <= w_rd_acc;
      r_count <= w_count_nxt;
      // Flags come from the next count so they always agree with count_o.
      r_full  <= (w_count_nxt == CNT_DEPTH);
      r_empty <= (w_count_nxt == CNT_ZERO);
      r_af    <= (w_count_nxt >= CNT_AF);
      r_ae    <= (w_count_nxt <= CNT_AE);
      r_ovf   <= wr_en_i & r_full;
      r_udf   <= rd_en_i & r_empty;
    end
  end

  assign data_o         = r_data;
  assign valid_o        = r_valid;
  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_af;
  assign almost_empty_o = r_ae;
  assign count_o        = r_count;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=8, AF=6, AE=2) with
// immediate assertions at every comparison point.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       valid;
  logic       full;
  logic       empty;
  logic       afull;
  logic       aempty;
  logic [3:0] count;
  logic       ovf;
  logic       udf;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_en),
    .data_i         (din),
    .rd_en_i        (rd_en),
    .data_o         (dout),
    .valid_o        (valid),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (afull),
    .almost_empty_o (aempty),
    .count_o        (count),
    .overflow_o     (ovf),
    .underflow_o    (udf)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock step: drive inputs, take the edge, sample 1 time unit later
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    // asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_data",   32'(dout),   32'h00);
    chk("rst_valid",  32'(valid),  32'd0);
    chk("rst_count",  32'(count),  32'd0);
    chk("rst_empty",  32'(empty),  32'd1);
    chk("rst_full",   32'(full),   32'd0);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_afull",  32'(afull),  32'd0);
    chk("rst_ovf",    32'(ovf),    32'd0);
    chk("rst_udf",    32'(udf),    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_count",  32'(count),  32'(i));
      chk("fill_empty",  32'(empty),  32'd0);
      chk("fill_aempty", 32'(aempty), (i <= 2) ? 32'd1 : 32'd0);
      chk("fill_afull",  32'(afull),  (i >= 6) ? 32'd1 : 32'd0);
      chk("fill_full",   32'(full),   (i == 8) ? 32'd1 : 32'd0);
      chk("fill_ovf",    32'(ovf),    32'd0);
    end
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_pulse", 32'(ovf),   32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full",  32'(full),  32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", 32'(ovf),   32'd0);

    // drain 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_data",  32'(dout),  32'(i));
      chk("drain_valid", 32'(valid), 32'd1);
      chk("drain_count", 32'(count), 32'(8 - i));
      chk("drain_empty", 32'(empty), (i == 8) ? 32'd1 : 32'd0);
      chk("drain_udf",   32'(udf),   32'd0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("udf_pulse", 32'(udf),   32'd1);
    chk("udf_valid", 32'(valid), 32'd0);
    chk("udf_hold",  32'(dout),  32'h08);
    step(1'b0, 8'h00, 1'b0);
    chk("udf_clear", 32'(udf),   32'd0);

    // wrap: write 5, read 5, then overlap across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_pre_data", 32'(dout), 32'(8'hA0 + i));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("wrap_count4", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h14 + i), 1'b1);
      chk("ovl_data",  32'(dout),  32'(8'h10 + i));
      chk("ovl_valid", 32'(valid), 32'd1);
      chk("ovl_count", 32'(count), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_tail", 32'(dout), 32'(8'h14 + i));
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // full with simultaneous write+read
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    chk("sim_full", 32'(full), 32'd1);
    step(1'b1, 8'h99, 1'b1);
    chk("simf_data",  32'(dout),  32'h30);
    chk("simf_valid", 32'(valid), 32'd1);
    chk("simf_ovf",   32'(ovf),   32'd1);
    chk("simf_count", 32'(count), 32'd7);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("simf_drain", 32'(dout), 32'(8'h30 + i));
    end
    chk("simf_empty", 32'(empty), 32'd1);

    // empty with simultaneous write+read
    step(1'b1, 8'hAA, 1'b1);
    chk("sime_udf",   32'(udf),   32'd1);
    chk("sime_count", 32'(count), 32'd1);
    chk("sime_valid", 32'(valid), 32'd0);
    chk("sime_hold",  32'(dout),  32'h37);
    step(1'b0, 8'h00, 1'b1);
    chk("sime_data",  32'(dout),  32'hAA);
    chk("sime_rvld",  32'(valid), 32'd1);
    chk("sime_cnt0",  32'(count), 32'd0);

    // reset in the middle of a write burst
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    chk("mid_count5", 32'(count), 32'd5);
    wr_en = 1'b1;
    din   = 8'h45;
    #2 rst = 1'b1;
    #1;
    chk("mid_count",  32'(count),  32'd0);
    chk("mid_empty",  32'(empty),  32'd1);
    chk("mid_aempty", 32'(aempty), 32'd1);
    chk("mid_valid",  32'(valid),  32'd0);
    wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_held", 32'(count), 32'd0);
    step(1'b1, 8'h55, 1'b0);
    chk("post_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_data",  32'(dout),  32'h55);
    chk("post_valid", 32'(valid), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("post_vdrop", 32'(valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
